// File: rtl/serial_adder_unit.sv
// Bit-serial adder: a single full-adder cell reused once per clock, LSB first,
// with a start/busy/done handshake plus unsigned carry-out and signed overflow flags.
module serial_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             fa_sum_s;
    logic             fa_cout_s;

    // Full-adder cell on the current bit pair and the held carry
    always_comb begin
        fa_sum_s  = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        fa_cout_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
        last_s    = (cnt_r == CNT_LAST);
    end

    // Next-state decode; start is only honoured in IDLE and DONE
    always_comb begin
        accept_s   = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, operand shifters, carry, counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                a_sh_r  <= a_in;
                b_sh_r  <= b_in;
                carry_r <= cin_in;
                cnt_r   <= {CNT_W{1'b0}};
                sum_r   <= {WIDTH{1'b0}};
                cout_r  <= 1'b0;
                ovf_r   <= 1'b0;
            end else if (state_r == ST_RUN) begin
                a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                carry_r <= fa_cout_s;
                sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
                // On the MSB step carry_r is the carry into the MSB
                if (last_s) begin
                    cout_r <= fa_cout_s;
                    ovf_r  <= carry_r ^ fa_cout_s;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                sum_r <= sum_r;
            end
        end
    end

    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign sum_out  = sum_r;
    assign cout_out = cout_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: WIDTH=8 vectors with hand-computed
// results plus an exhaustive WIDTH=4 sweep against a+b+cin.
module tb_serial_adder_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       cin_in = 1'b0;
    logic       busy, done, cout_out, overflow;
    logic [7:0] sum_out;

    logic       start4 = 1'b0;
    logic [3:0] a4 = 4'h0;
    logic [3:0] b4 = 4'h0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_unit #(.WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .cin_in(cin_in), .busy(busy), .done(done), .sum_out(sum_out),
        .cout_out(cout_out), .overflow(overflow)
    );

    serial_adder_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4),
        .cin_in(cin4), .busy(busy4), .done(done4), .sum_out(sum4),
        .cout_out(cout4), .overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition; optionally scrambles the operand inputs during RUN
    task automatic do_add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input bit scramble,
                           input logic [7:0] es, input logic ec, input logic eo);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin; start = 1'b1;
        cycles = 0; busy_cnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy) busy_cnt++;
            if (scramble) begin
                a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
            end
        end while (!done && cycles < 20);
        check({tag, "_latency"}, 32'(cycles), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_sum"}, 32'(sum_out), 32'(es));
        check({tag, "_cout"}, 32'(cout_out), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_sum"}, 32'(sum_out), 32'(es));
    endtask

    task automatic do_add4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int cycles;
        logic [4:0] exp5;
        logic [3:0] es;
        exp5 = 5'(a) + 5'(b) + 5'(cin);
        es = exp5[3:0];
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cycles++;
        end while (!done4 && cycles < 12);
        check("w4_latency", 32'(cycles), 32'd5);
        check("w4_result", 32'({cout4, sum4}), 32'(exp5));
        check("w4_ovf", 32'(ovf4), 32'((a[3] == b[3]) && (es[3] != a[3])));
    endtask

    initial begin
        int npulse;
        int consec;
        int dcount;
        logic prev;

        // reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        do_add8("t7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add8("tff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add8("t80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        do_add8("t0f_f0c", 8'h0F, 8'hF0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        do_add8("t12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        do_add8("t00_00c", 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

        // start held high: back-to-back runs, done every 9th cycle
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
        prev = 1'b0; npulse = 0; consec = 0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            check("hold_done_slot", 32'(done), 32'(i % 9 == 0));
            if (done) begin
                npulse++;
                if (prev) consec++;
                check("hold_sum", 32'(sum_out), 32'h46);
            end
            prev = done;
            if (i == 27) start = 1'b0;
        end
        check("hold_npulse", 32'(npulse), 32'd3);
        check("hold_consec", 32'(consec), 32'd0);
        @(negedge clk);
        check("hold_idle_busy", 32'(busy), 32'd0);

        // reset during RUN discards the partial result
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h55; cin_in = 1'b0; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        reset = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        do_add8("t55_55", 8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);

        // exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    do_add4(4'(a), 4'(b), 1'(c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
